text_tile_engine: RTL and testbench

TEXT_TILE_ENGINE -- requirements
Module: text_tile_engine

---
 rtl/text_pkg.sv | 26 ++
 rtl/cell_ram.sv | 30 +++
 rtl/font_rom.sv | 55 +++++
 rtl/text_tile_engine.sv | 234 +++++++++++++++++++++++
 tb/tb_text_tile_engine.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/text_pkg.sv
// Shared definitions for the text tile engine: cell-word layout, font
// geometry, the blank character and the control FSM state encoding.
package text_pkg;

   // Font cell geometry in native (unscaled) pixels.
   localparam int FONT_W = 8;
   localparam int FONT_H = 16;

   // Cell word layout: {blink, rgb[2:0], char[6:0]}.
   localparam int CELL_W    = 11;
   localparam int CHAR_LSB  = 0;
   localparam int CHAR_W    = 7;
   localparam int RGB_LSB   = 7;
   localparam int RGB_W     = 3;
   localparam int BLINK_BIT = 10;

   // Code written into every cell by a clear sweep.
   localparam logic [CHAR_W-1:0] BLANK_CHAR = 7'h00;

   // Control FSM: normal operation or clear sweep in progress.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } ctrl_state_e;

endpackage

// File: rtl/cell_ram.sv
// Cell buffer: one write port, one synchronous read port. A read and a
// write of the same address on the same edge return the old word.
module cell_ram #(
   parameter  int DEPTH = 600,
   parameter  int WIDTH = 11,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write and registered read share one edge; the read sees the pre-write word.
   // NOTE: non-blocking assignments make the read sample mem before the write
   // updates it (read-first); blocking here would change the ordering.
   // NOTE: the array is deliberately not reset -- a RAM cannot be cleared in
   // one cycle; the control FSM sweeps it instead.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
      rdata_o <= mem[raddr_i];
   end

endmodule

// File: rtl/font_rom.sv
// Glyph ROM: address {char[6:0], glyph_row[3:0]}, 8-bit row bitmap with the
// leftmost pixel in bit 7, one clock of read latency. Codes without a
// bitmap read as blank.
module font_rom (
   input  logic        clk,
   input  logic [10:0] addr_i,
   output logic [7:0]  data_o
);

   logic [7:0] glyph_d;

   // Bitmap lookup for the addressed glyph row.
   // NOTE: glyph_d gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      glyph_d = 8'h00;
      case (addr_i[10:4])
         7'h41: begin // 'A'
            case (addr_i[3:0])
               4'd2:                      glyph_d = 8'h10;
               4'd3:                      glyph_d = 8'h38;
               4'd4:                      glyph_d = 8'h6c;
               4'd7:                      glyph_d = 8'hfe;
               4'd5, 4'd6, 4'd8, 4'd9,
               4'd10, 4'd11:              glyph_d = 8'hc6;
               default:                   glyph_d = 8'h00;
            endcase
         end
         7'h48: begin // 'H'
            case (addr_i[3:0])
               4'd6:                      glyph_d = 8'hfe;
               4'd2, 4'd3, 4'd4, 4'd5,
               4'd7, 4'd8, 4'd9, 4'd10,
               4'd11:                     glyph_d = 8'hc6;
               default:                   glyph_d = 8'h00;
            endcase
         end
         7'h49: begin // 'I'
            case (addr_i[3:0])
               4'd2, 4'd11:               glyph_d = 8'h3c;
               4'd3, 4'd4, 4'd5, 4'd6,
               4'd7, 4'd8, 4'd9, 4'd10:   glyph_d = 8'h18;
               default:                   glyph_d = 8'h00;
            endcase
         end
         default: glyph_d = 8'h00;
      endcase
   end

   // Registered ROM output.
   always_ff @(posedge clk) begin
      data_o <= glyph_d;
   end

endmodule

// File: rtl/text_tile_engine.sv
// Character-cell text overlay for a VGA pixel stream. A cell buffer holds
// {blink, rgb, char} per cell; a three-stage pipeline (buffer read, font
// read, output register) turns the pixel coordinate into a colour. A small
// FSM accepts cell writes or sweeps the buffer clear.
module text_tile_engine
   import text_pkg::*;
#(
   parameter  int COLS         = 40,
   parameter  int ROWS         = 15,
   parameter  int SCALE_LOG2   = 1,
   parameter  int BLINK_FRAMES = 30,
   localparam int RW           = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int CW           = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [9:0]    pix_x,
   input  logic [9:0]    pix_y,
   input  logic          video_on,
   input  logic          frame_tick,
   input  logic          wr_en,
   input  logic [RW-1:0] wr_row,
   input  logic [CW-1:0] wr_col,
   input  logic [6:0]    wr_char,
   input  logic [2:0]    wr_rgb,
   input  logic          wr_blink,
   input  logic          clr_req,
   input  logic [2:0]    bg_rgb,
   output logic          wr_ready,
   output logic          text_on,
   output logic [2:0]    text_rgb
);

   localparam int DEPTH = ROWS * COLS;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int GR_W  = $clog2(FONT_H);
   localparam int GB_W  = $clog2(FONT_W);

   localparam logic [CELL_W-1:0] CLEAR_WORD = {1'b0, 3'b000, BLANK_CHAR};

   // ---------------------------------------------------------------
   // Stage 0: pixel coordinate -> cell address and glyph position
   // ---------------------------------------------------------------
   logic [9:0]      cell_col;
   logic [9:0]      cell_row;
   logic [GR_W-1:0] glyph_row;
   logic [GB_W-1:0] glyph_bit;
   logic            in_area;
   logic [AW-1:0]   rd_addr;

   assign cell_col  = pix_x >> (GB_W + SCALE_LOG2);
   assign cell_row  = pix_y >> (GR_W + SCALE_LOG2);
   assign glyph_row = GR_W'(pix_y >> SCALE_LOG2);
   assign glyph_bit = GB_W'(pix_x >> SCALE_LOG2);
   assign in_area   = video_on && (32'(cell_col) < COLS) && (32'(cell_row) < ROWS);
   // Off-area coordinates would alias other cells or run past the buffer.
   assign rd_addr   = in_area ? AW'(32'(cell_row) * COLS + 32'(cell_col)) : '0;

   // ---------------------------------------------------------------
   // Write port: user writes or clear sweep
   // ---------------------------------------------------------------
   ctrl_state_e       state_q, state_d;
   logic [AW-1:0]     clr_addr_q, clr_addr_d;
   logic              ram_we;
   logic [AW-1:0]     ram_waddr;
   logic [CELL_W-1:0] ram_wdata;
   logic              wr_in_range;
   logic [AW-1:0]     wr_addr_user;
   logic [CELL_W-1:0] wr_word_user;
   logic [CELL_W-1:0] rd_word;
   logic [7:0]        font_word;

   assign wr_in_range  = (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
   assign wr_addr_user = AW'(32'(wr_row) * COLS + 32'(wr_col));
   assign wr_word_user = {wr_blink, wr_rgb, wr_char};

   // Control state and sweep address; reset starts a clear from address 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   // Next state and write-port steering; clear wins over a same-cycle write.
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      ram_we     = 1'b0;
      ram_waddr  = wr_addr_user;
      ram_wdata  = wr_word_user;
      wr_ready   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            wr_ready = 1'b1;
            if (clr_req) begin
               state_d    = ST_CLEAR;
               clr_addr_d = '0;
            end else if (wr_en && wr_in_range) begin
               ram_we = 1'b1;
            end
         end
         ST_CLEAR: begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr_q;
            ram_wdata = CLEAR_WORD;
            if (clr_addr_q == AW'(DEPTH - 1)) begin
               state_d    = ST_IDLE;
               clr_addr_d = '0;
            end else begin
               clr_addr_d = clr_addr_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   cell_ram #(
      .DEPTH (DEPTH),
      .WIDTH (CELL_W)
   ) u_cell_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .raddr_i (rd_addr),
      .rdata_o (rd_word)
   );

   // ---------------------------------------------------------------
   // Blink timebase
   // ---------------------------------------------------------------
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_phase_q, blink_phase_d;

   // Count frame ticks; flip the phase each time the count wraps.
   always_comb begin
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (frame_tick) begin
         if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   // Blink counter and phase registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else begin
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   // ---------------------------------------------------------------
   // Display pipeline stages 1..3
   // ---------------------------------------------------------------
   logic            valid_q1, valid_q2;
   logic [GR_W-1:0] glyph_row_q1;
   logic [GB_W-1:0] glyph_bit_q1, glyph_bit_q2;
   logic            blink_q2;
   logic [2:0]      rgb_q2;

   // Stage 1 side-band: travels alongside the buffer read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q1     <= 1'b0;
         glyph_row_q1 <= '0;
         glyph_bit_q1 <= '0;
      end else begin
         valid_q1     <= in_area;
         glyph_row_q1 <= glyph_row;
         glyph_bit_q1 <= glyph_bit;
      end
   end

   font_rom u_font_rom (
      .clk    (clk),
      .addr_i ({rd_word[CHAR_LSB +: CHAR_W], glyph_row_q1}),
      .data_o (font_word)
   );

   // Stage 2 side-band: cell attributes travel alongside the font read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q2     <= 1'b0;
         glyph_bit_q2 <= '0;
         blink_q2     <= 1'b0;
         rgb_q2       <= '0;
      end else begin
         valid_q2     <= valid_q1;
         glyph_bit_q2 <= glyph_bit_q1;
         blink_q2     <= rd_word[BLINK_BIT];
         rgb_q2       <= rd_word[RGB_LSB +: RGB_W];
      end
   end

   logic       lit;
   logic       text_on_d, text_on_q;
   logic [2:0] text_rgb_d, text_rgb_q;

   // Pixel decision: glyph bit set, inside the text area, not blinked out.
   always_comb begin
      lit        = valid_q2 && font_word[GB_W'(FONT_W - 1) - glyph_bit_q2] &&
                   !(blink_q2 && blink_phase_q);
      text_on_d  = lit;
      text_rgb_d = lit ? rgb_q2 : bg_rgb;
   end

   // Stage 3: registered pixel output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         text_on_q  <= 1'b0;
         text_rgb_q <= 3'b000;
      end else begin
         text_on_q  <= text_on_d;
         text_rgb_q <= text_rgb_d;
      end
   end

   assign text_on  = text_on_q;
   assign text_rgb = text_rgb_q;

endmodule

// File: tb/tb_text_tile_engine.sv
// Directed bench for text_tile_engine at default parameters
// (40x15 cells, 2x glyph scale, 30-frame blink half-period).
module tb_text_tile_engine;

   localparam int COLS = 40;
   localparam int ROWS = 15;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] pix_x, pix_y;
   logic       video_on, frame_tick;
   logic       wr_en;
   logic [3:0] wr_row;
   logic [5:0] wr_col;
   logic [6:0] wr_char;
   logic [2:0] wr_rgb;
   logic       wr_blink;
   logic       clr_req;
   logic [2:0] bg_rgb;
   logic       wr_ready, text_on;
   logic [2:0] text_rgb;

   int checks = 0;
   int errors = 0;

   // Reference bitmap of 'H' (8x16, leftmost pixel in bit 7).
   logic [7:0] font_h [16] = '{8'h00, 8'h00, 8'hc6, 8'hc6, 8'hc6, 8'hc6, 8'hfe, 8'hc6,
                               8'hc6, 8'hc6, 8'hc6, 8'hc6, 8'h00, 8'h00, 8'h00, 8'h00};

   logic       exp_on_a  [512];
   logic [2:0] exp_rgb_a [512];

   text_tile_engine #(
      .COLS         (COLS),
      .ROWS         (ROWS),
      .SCALE_LOG2   (1),
      .BLINK_FRAMES (30)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .video_on   (video_on),
      .frame_tick (frame_tick),
      .wr_en      (wr_en),
      .wr_row     (wr_row),
      .wr_col     (wr_col),
      .wr_char    (wr_char),
      .wr_rgb     (wr_rgb),
      .wr_blink   (wr_blink),
      .clr_req    (clr_req),
      .bg_rgb     (bg_rgb),
      .wr_ready   (wr_ready),
      .text_on    (text_on),
      .text_rgb   (text_rgb)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic write_cell(input logic [3:0] row, input logic [5:0] col,
                             input logic [6:0] ch, input logic [2:0] rgb, input logic blink);
      wr_row   = row;
      wr_col   = col;
      wr_char  = ch;
      wr_rgb   = rgb;
      wr_blink = blink;
      wr_en    = 1'b1;
      step();
      wr_en    = 1'b0;
   endtask

   task automatic check_pix(input string tag, input int x, input int y, input logic von,
                            input logic exp_on, input logic [2:0] exp_rgb);
      pix_x    = 10'(x);
      pix_y    = 10'(y);
      video_on = von;
      steps(3);
      check({tag, "_on"},  32'(text_on),  32'(exp_on));
      check({tag, "_rgb"}, 32'(text_rgb), 32'(exp_rgb));
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         step();
      end
   endtask

   // Counts cycles with wr_ready low (bounded); optionally pulses clr_req
   // once at cycle clr_at to confirm it is ignored mid-sweep.
   task automatic count_clear(output int n, input int clr_at);
      n = 0;
      while (wr_ready !== 1'b1 && n < 2000) begin
         n++;
         if (n == clr_at) clr_req = 1'b1;
         step();
         clr_req = 1'b0;
      end
   endtask

   initial begin
      int n;
      int x, y, gr, gb;
      logic lit;

      reset      = 1'b1;
      pix_x      = 10'd32;
      pix_y      = 10'd12;
      video_on   = 1'b1;
      frame_tick = 1'b0;
      wr_en      = 1'b1;
      wr_row     = 4'd0;
      wr_col     = 6'd0;
      wr_char    = 7'h48;
      wr_rgb     = 3'b111;
      wr_blink   = 1'b0;
      clr_req    = 1'b0;
      bg_rgb     = 3'b110;

      // Reset state.
      steps(3);
      check("rst_text_on",  32'(text_on),  32'd0);
      check("rst_text_rgb", 32'(text_rgb), 32'd0);
      check("rst_wr_ready", 32'(wr_ready), 32'd0);

      // Release, then re-assert reset mid-sweep: the sweep restarts.
      reset = 1'b0;
      steps(100);
      check("mid_clear_wr_ready", 32'(wr_ready), 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      count_clear(n, -1);
      wr_en = 1'b0;
      check("reset_clear_cycles", 32'(n), 32'd600);
      check("ready_after_clear", 32'(wr_ready), 32'd1);

      // wr_en was held through the sweep; cell (0,0) must still be blank.
      check_pix("no_write_in_clear", 0, 12, 1'b1, 1'b0, 3'b110);

      // 'H' at row 0 col 2; stream every pixel of the cell, one per clock.
      write_cell(4'd0, 6'd2, 7'h48, 3'b001, 1'b0);
      for (int k = 0; k < 515; k++) begin
         if (k >= 3) begin
            check($sformatf("scan%0d_on", k - 3),  32'(text_on),  32'(exp_on_a[k - 3]));
            check($sformatf("scan%0d_rgb", k - 3), 32'(text_rgb), 32'(exp_rgb_a[k - 3]));
         end
         if (k < 512) begin
            x  = 32 + (k % 16);
            y  = k / 16;
            gr = y / 2;
            gb = (x / 2) % 8;
            lit = font_h[gr][7 - gb];
            exp_on_a[k]  = lit;
            exp_rgb_a[k] = lit ? 3'b001 : 3'b110;
            pix_x    = 10'(x);
            pix_y    = 10'(y);
            video_on = 1'b1;
         end
         step();
      end

      // Blink: same cell with blink set, plus a steady cell at col 3.
      write_cell(4'd0, 6'd3, 7'h48, 3'b010, 1'b0);
      write_cell(4'd0, 6'd2, 7'h48, 3'b001, 1'b1);
      check_pix("blink_start", 32, 12, 1'b1, 1'b1, 3'b001);
      ticks(29);
      check_pix("blink_29", 32, 12, 1'b1, 1'b1, 3'b001);
      ticks(1);
      check_pix("blink_30", 32, 12, 1'b1, 1'b0, 3'b110);
      check_pix("steady_in_off", 48, 12, 1'b1, 1'b1, 3'b010);
      ticks(29);
      check_pix("blink_59", 32, 12, 1'b1, 1'b0, 3'b110);
      ticks(1);
      check_pix("blink_60", 32, 12, 1'b1, 1'b1, 3'b001);

      // Out-of-range writes are dropped (col 40 would alias row 1 col 0).
      write_cell(4'd15, 6'd0, 7'h48, 3'b100, 1'b0);
      write_cell(4'd0, 6'd40, 7'h48, 3'b100, 1'b0);
      check_pix("oor_dropped", 0, 44, 1'b1, 1'b0, 3'b110);
      write_cell(4'd1, 6'd0, 7'h48, 3'b100, 1'b0);
      check_pix("inrange_ok", 0, 44, 1'b1, 1'b1, 3'b100);

      // Same-cycle write and display read of row 2 col 0: old word first.
      pix_x    = 10'd0;
      pix_y    = 10'd76;
      video_on = 1'b1;
      wr_row   = 4'd2;
      wr_col   = 6'd0;
      wr_char  = 7'h48;
      wr_rgb   = 3'b011;
      wr_blink = 1'b0;
      wr_en    = 1'b1;
      step();
      wr_en = 1'b0;
      steps(2);
      check("rf_old_on",  32'(text_on),  32'd0);
      check("rf_old_rgb", 32'(text_rgb), 32'(3'b110));
      step();
      check("rf_new_on",  32'(text_on),  32'd1);
      check("rf_new_rgb", 32'(text_rgb), 32'(3'b011));

      // Outside the text area or blanked video: background only.
      check_pix("x640",      640, 12,  1'b1, 1'b0, 3'b110);
      check_pix("y480",      0,   480, 1'b1, 1'b0, 3'b110);
      check_pix("video_off", 32,  12,  1'b0, 1'b0, 3'b110);

      // Clear together with a write: clear wins, a mid-sweep clr_req is ignored.
      wr_row  = 4'd3;
      wr_col  = 6'd0;
      wr_char = 7'h48;
      wr_rgb  = 3'b101;
      wr_en   = 1'b1;
      clr_req = 1'b1;
      step();
      wr_en   = 1'b0;
      clr_req = 1'b0;
      count_clear(n, 300);
      check("clr_cycles", 32'(n), 32'd600);
      check_pix("clr_c02", 32, 12,  1'b1, 1'b0, 3'b110);
      check_pix("clr_c03", 48, 12,  1'b1, 1'b0, 3'b110);
      check_pix("clr_c10", 0,  44,  1'b1, 1'b0, 3'b110);
      check_pix("clr_c20", 0,  76,  1'b1, 1'b0, 3'b110);
      check_pix("clr_c30", 0,  108, 1'b1, 1'b0, 3'b110);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
